// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Memory-mapped, time-multiplexed seven-segment display
//               controller. The CPU writes hex content, per-digit enable,
//               decimal-point and control registers. The block scans DIGITS
//               digits at SCAN_HZ and drives shared anode/segment lines.
//               Optional per-digit blinking is built only when the macro
//               SEG_BLINK_EN is defined; the default build has no blink logic.
// Ports       : clock, reset  - system clock, synchronous active-high reset
//               sel, we       - chip select and write strobe (write = sel&we)
//               addr, din     - byte address (addr[3:2] decoded), write data
//               dout          - combinational read data (0 when sel=0)
//               an            - digit select, one-hot when active
//               seg           - segments a..g on bits 0..6, dp on bit 7
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int CLK_HZ      = 10000000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLINK_TICKS = 500,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg
);

  localparam int DIV   = (CLK_HZ / SCAN_HZ < 1) ? 1 : CLK_HZ / SCAN_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CUR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] C_AN_IDLE  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        C_SEG_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Raw a..g pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Register file
  logic [4*DIGITS-1:0] content_q;
  logic [DIGITS-1:0]   en_q;
  logic [DIGITS-1:0]   dp_q;
  logic                blank_q;

  // Scan state. run_q is low for the first edge after reset so that the
  // counters hold at zero and the outputs stay idle for that edge.
  logic              run_q;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CUR_W-1:0]  cur_q, cur_d;
  logic [DIGITS-1:0] an_q;
  logic [7:0]        seg_q;

  logic              w_tick;
  logic              w_wr;
  logic              w_blink_hide;
  logic              w_vis;
  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_an_raw;
  logic [7:0]        w_seg_raw;
  logic [31:0]       w_rdata;

  assign w_wr   = sel & we;
  assign w_tick = (div_cnt_q == DIV_W'(DIV - 1));

  always_comb begin
    div_cnt_d = w_tick ? '0 : div_cnt_q + DIV_W'(1);
    cur_d     = cur_q;
    if (w_tick) begin
      cur_d = (cur_q == CUR_W'(DIGITS - 1)) ? '0 : cur_q + CUR_W'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic            blink_on_q;
  logic [7:0]      blink_mask_q;
  logic [BT_W-1:0] blink_cnt_q;
  logic            blink_phase_q;

  // Mask bits above DIGITS-1 are stored for readback but never selected.
  assign w_blink_hide = blink_on_q & blink_mask_q[3'(cur_q)] & blink_phase_q;

  // Blink counter advances on scan ticks and runs whether or not blinking
  // is enabled, so the blink phase stays aligned with the scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_on_q    <= 1'b0;
      blink_mask_q  <= 8'h00;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      if (run_q && w_tick) begin
        if (blink_cnt_q == BT_W'(BLINK_TICKS - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BT_W'(1);
        end
      end
      if (w_wr && addr[3:2] == 2'd3) begin
        blink_on_q   <= din[1];
        blink_mask_q <= din[15:8];
      end
    end
  end
`else
  assign w_blink_hide = 1'b0;
`endif

  // Output datapath for the digit currently under scan.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_an_raw[i] = (cur_q == CUR_W'(i));
    end
    w_nib     = content_q[{cur_q, 2'b00} +: 4];
    w_vis     = en_q[cur_q] & ~blank_q & ~w_blink_hide;
    w_seg_raw = w_vis ? {dp_q[cur_q], hex7(w_nib)} : 8'h00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      content_q <= '0;
      en_q      <= '1;
      dp_q      <= '0;
      blank_q   <= 1'b0;
      run_q     <= 1'b0;
      div_cnt_q <= '0;
      cur_q     <= '0;
      an_q      <= C_AN_IDLE;
      seg_q     <= C_SEG_IDLE;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        div_cnt_q <= div_cnt_d;
        cur_q     <= cur_d;
        an_q      <= (ACTIVE_LOW != 0) ? ~w_an_raw  : w_an_raw;
        seg_q     <= (ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;
      end else begin
        an_q  <= C_AN_IDLE;
        seg_q <= C_SEG_IDLE;
      end
      if (w_wr) begin
        case (addr[3:2])
          2'd0:    content_q <= din[4*DIGITS-1:0];
          2'd1:    en_q      <= din[DIGITS-1:0];
          2'd2:    dp_q      <= din[DIGITS-1:0];
          default: blank_q   <= din[0];
        endcase
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

  // Read mux; unimplemented bits read as zero.
  always_comb begin
    w_rdata = '0;
    case (addr[3:2])
      2'd0:    w_rdata[4*DIGITS-1:0] = content_q;
      2'd1:    w_rdata[DIGITS-1:0]   = en_q;
      2'd2:    w_rdata[DIGITS-1:0]   = dp_q;
      default: begin
        w_rdata[0] = blank_q;
`ifdef SEG_BLINK_EN
        w_rdata[1]    = blink_on_q;
        w_rdata[15:8] = blink_mask_q;
`endif
      end
    endcase
    dout = sel ? w_rdata : 32'h0;
  end

  logic w_unused;
  assign w_unused = ^{addr[31:4], addr[1:0], din, BLINK_TICKS[0]};

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl. Two instances share
//               one bus: A (8 digits, DIV=8, active-low) and B (3 digits,
//               DIV=1, active-high). A cycle-level reference derives the
//               expected outputs from the edge count since reset and the
//               register contents written so far.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [31:0] addr, din;
  logic [31:0] dout_a, dout_b;
  logic [7:0]  an_a, seg_a, seg_b;
  logic [2:0]  an_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(8), .CLK_HZ(8000), .SCAN_HZ(1000), .BLINK_TICKS(2), .ACTIVE_LOW(1)) u_a (
    .clock(clk), .reset(rst), .sel(sel), .we(we), .addr(addr), .din(din),
    .dout(dout_a), .an(an_a), .seg(seg_a));

  seg_scan_ctrl #(.DIGITS(3), .CLK_HZ(1000), .SCAN_HZ(1000), .BLINK_TICKS(3), .ACTIVE_LOW(0)) u_b (
    .clock(clk), .reset(rst), .sel(sel), .we(we), .addr(addr), .din(din),
    .dout(dout_b), .an(an_b), .seg(seg_b));

  // ---------------- reference model ----------------
  logic [7:0] pat [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [31:0] m_content, m_en, m_dp, m_ctrl;
  int          kk;       // edges since reset released (1 = first edge)
  bit          inrst;
  logic [7:0]  e_an_a, e_seg_a, e_seg_b;
  logic [2:0]  e_an_b;

  // Expected outputs after an edge, from the pre-edge registers and edge index.
  task automatic model_out(input int digits, input int div, input int bt, input bit al,
                           output logic [7:0] an_e, output logic [7:0] seg_e);
    int ticks, cur, ph;
    bit vis;
    logic [7:0] a, s;
    a = 8'h00; s = 8'h00;
    if (!inrst && kk >= 2) begin
      ticks = (kk - 2) / div;  // ticks completed before this edge
      cur   = ticks % digits;
      ph    = (ticks / bt) % 2;
      a     = 8'h01 << cur;
      vis   = m_en[cur] && !m_ctrl[0];
`ifdef SEG_BLINK_EN
      if (m_ctrl[1] && m_ctrl[8 + cur] && ph == 1) vis = 0;
`endif
      if (vis) s = {m_dp[cur], pat[m_content[4*cur +: 4]][6:0]};
    end
    if (al) begin a = ~a; s = ~s; end
    an_e  = a & 8'((1 << digits) - 1);
    seg_e = s;
  endtask

  function automatic logic [31:0] model_rd(input int digits, input logic [1:0] a);
    logic [31:0] m;
    m = (digits == 8) ? 32'hFFFF_FFFF : (32'h1 << (4 * digits)) - 32'h1;
    case (a)
      2'd0:    return m_content & m;
      2'd1:    return m_en & ((32'h1 << digits) - 32'h1);
      2'd2:    return m_dp & ((32'h1 << digits) - 32'h1);
`ifdef SEG_BLINK_EN
      default: return m_ctrl & 32'h0000_FF03;
`else
      default: return m_ctrl & 32'h0000_0001;
`endif
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin kk = 0; inrst = 1; end
    else begin kk = kk + 1; inrst = 0; end
    model_out(8, 8, 2, 1'b1, e_an_a, e_seg_a);
    begin
      logic [7:0] tmp;
      model_out(3, 1, 3, 1'b0, tmp, e_seg_b);
      e_an_b = tmp[2:0];
    end
    if (rst) begin
      m_content = 0; m_en = 32'hFFFF_FFFF; m_dp = 0; m_ctrl = 0;
    end else if (sel && we) begin
      case (addr[3:2])
        2'd0: m_content = din;
        2'd1: m_en      = din;
        2'd2: m_dp      = din;
        default: m_ctrl = din;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [31:0] ra, rb;
    #3;
    n_chk++;
    if (an_a !== e_an_a || seg_a !== e_seg_a) begin
      n_fail++;
      $display("FAIL cyc_a t=%0t an=%h seg=%h expected an=%h seg=%h", $time, an_a, seg_a, e_an_a, e_seg_a);
    end
    n_chk++;
    if (an_b !== e_an_b || seg_b !== e_seg_b) begin
      n_fail++;
      $display("FAIL cyc_b t=%0t an=%h seg=%h expected an=%h seg=%h", $time, an_b, seg_b, e_an_b, e_seg_b);
    end
    ra = sel ? model_rd(8, addr[3:2]) : 32'h0;
    rb = sel ? model_rd(3, addr[3:2]) : 32'h0;
    n_chk++;
    if (dout_a !== ra || dout_b !== rb) begin
      n_fail++;
      $display("FAIL cyc_dout t=%0t a=%h b=%h expected a=%h b=%h", $time, dout_a, dout_b, ra, rb);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); sel = 1; we = 1; addr = a; din = d;
    @(negedge clk); sel = 0; we = 0;
  endtask

  task automatic wait_an(input string name, input logic [7:0] v);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #3;
      if (an_a === v) ok = 1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout an=%h expected=%h", name, an_a, v);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; sel = 0; we = 0; addr = 0; din = 0;
    repeat (3) @(posedge clk);
    #3; lit("rst_an", an_a, 8'hFF); lit("rst_seg", seg_a, 8'hFF);
    @(negedge clk) rst = 0;
    @(posedge clk); #3; lit("edge1_an", an_a, 8'hFF); lit("edge1_seg", seg_a, 8'hFF);
    @(posedge clk); #3; lit("edge2_an", an_a, 8'hFE); lit("edge2_seg", seg_a, 8'hC0);
    lit("edge2_an_b", an_b, 3'b001); lit("edge2_seg_b", seg_b, 8'h3F);
    @(posedge clk); #3; lit("edge3_an_b", an_b, 3'b010);
    repeat (6) @(posedge clk); #3; lit("edge9_an", an_a, 8'hFE);
    @(posedge clk); #3; lit("edge10_an", an_a, 8'hFD);

    wr(32'h0, 32'h7654_3210);
    wr(32'h8, 32'h0000_0001);
    wait_an("find_d0", 8'hFE); lit("d0_seg_dp", seg_a, 8'h40);
    repeat (64) @(posedge clk); #3; lit("frame64_an", an_a, 8'hFE);
    wait_an("find_d5", 8'hDF); lit("d5_seg", seg_a, 8'h92);

    wr(32'h4, 32'h0000_000F);
    wait_an("find_d4", 8'hEF); lit("d4_off_seg", seg_a, 8'hFF);
    wait_an("find_d7", 8'h7F); lit("d7_off_seg", seg_a, 8'hFF);
    wr(32'h4, 32'hFFFF_FFFF);

    wr(32'hC, 32'h1);
    @(posedge clk); #3; lit("blank_seg_a", seg_a, 8'hFF); lit("blank_seg_b", seg_b, 8'h00);
    wr(32'hC, 32'h0);

    @(negedge clk); sel = 1; addr = 32'h4; #1;
    lit("rd_en_a", dout_a, 32'h0000_00FF); lit("rd_en_b", dout_b, 32'h0000_0007);
    @(negedge clk); sel = 0; #1; lit("rd_nosel", dout_a, 32'h0);

    wr(32'hC, 32'h0302);
    @(negedge clk); sel = 1; addr = 32'hC; #1;
`ifdef SEG_BLINK_EN
    lit("rd_ctrl", dout_a, 32'h0000_0302);
`else
    lit("rd_ctrl", dout_a, 32'h0);
`endif
    @(negedge clk); sel = 0;
    repeat (200) @(posedge clk);

    // mid-scan reset
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      @(negedge clk);
      r    = $urandom;
      rst  = ($urandom_range(0, 799) == 0);
      sel  = r[0] | r[1];
      we   = (r[4:2] == 3'd0);
      addr = {$urandom} & 32'hFFFF_FFFC | {30'h0, r[9:8]};
      din  = $urandom;
      if (addr[3:2] == 2'd3 && r[7:5] != 3'd0) din[0] = 1'b0;
    end
    @(negedge clk); rst = 0; sel = 0; we = 0;
    repeat (20) @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
